// File: rtl/laser_host_if.sv
// ---------------------------------------------------------------------------
// laser_host_if
// Bundles every non-clock signal of the laser host: the point-memory write
// port, the run control, the engine stream (x/y out, centres and done in) and
// the result bus.
//   slave  : the laser_host block itself
//   master : the environment (system write port plus the laser engine)
// ---------------------------------------------------------------------------
interface laser_host_if;
  // system write port and run control
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [3:0] wr_x;
  logic [3:0] wr_y;
  logic       start;
  logic       busy;
  // engine stream
  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] c1x;
  logic [3:0] c1y;
  logic [3:0] c2x;
  logic [3:0] c2y;
  logic       done;
  // result bus
  logic       res_valid;
  logic [3:0] res_c1x;
  logic [3:0] res_c1y;
  logic [3:0] res_c2x;
  logic [3:0] res_c2y;
  logic [5:0] res_cover;
  logic       res_timeout;

  modport slave (
    input  wr_en, wr_addr, wr_x, wr_y, start,
    input  c1x, c1y, c2x, c2y, done,
    output busy, x, y,
    output res_valid, res_c1x, res_c1y, res_c2x, res_c2y, res_cover, res_timeout
  );

  modport master (
    output wr_en, wr_addr, wr_x, wr_y, start,
    output c1x, c1y, c2x, c2y, done,
    input  busy, x, y,
    input  res_valid, res_c1x, res_c1y, res_c2x, res_c2y, res_cover, res_timeout
  );
endinterface

// File: rtl/laser_host.sv
// ---------------------------------------------------------------------------
// laser_host
// Stimulus and scoring front end for the two-circle laser engine. Holds a
// point set written through the system port, streams it to the engine one
// point per cycle, waits for the engine's done pulse, latches the two circle
// centres and then counts the points covered by either circle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : laser_host_if.slave -- write port, start/busy, engine x/y and
//           centres/done, result bus (res_valid pulse with centres, cover
//           count and timeout flag)
// Flow: IDLE -> SEND -> WAIT -> SCORE -> REPORT -> IDLE, WAIT -> REPORT on
// timeout. Latency from start to res_valid is N_PTS + W + N_PTS + 2 cycles
// counting the start cycle and the report cycle, W being the WAIT cycles.
// ---------------------------------------------------------------------------
module laser_host #(
  parameter int N_PTS   = 40,    // points per set (address width is 6)
  parameter int R_SQ    = 16,    // squared radius of both circles
  parameter int TIMEOUT = 8192   // WAIT cycles before the run is abandoned
) (
  input logic         clk,
  input logic         rst_n,
  laser_host_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_SCORE,
    S_REPORT
  } state_t;

  state_t      state;
  logic [5:0]  idx;        // point being sent or scored
  logic [15:0] wait_cnt;   // cycles spent in WAIT

  logic [3:0]  x_q, y_q;
  logic        res_valid_q, res_timeout_q;
  logic [3:0]  res_c1x_q, res_c1y_q, res_c2x_q, res_c2y_q;
  logic [5:0]  res_cover_q;

  logic [3:0]  mem_x [N_PTS];
  logic [3:0]  mem_y [N_PTS];

  // NOTE: the point memory has no reset on purpose: it must survive a reset
  // so a run can be restarted on the same set, and leaving it out of the reset
  // tree lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.wr_en && bus.wr_addr < 6'(N_PTS)) begin
      mem_x[bus.wr_addr] <= bus.wr_x;
      mem_y[bus.wr_addr] <= bus.wr_y;
    end
  end

  // Squared distance test in the widths the engine uses: |d| in 4 bits,
  // squares in 8 bits, sum in 9 bits so 15^2 + 15^2 cannot wrap.
  function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [7:0] sq_x, sq_y;
    logic [8:0] sum;
    dx   = (px >= cx) ? px - cx : cx - px;
    dy   = (py >= cy) ? py - cy : cy - py;
    sq_x = {4'd0, dx} * {4'd0, dx};
    sq_y = {4'd0, dy} * {4'd0, dy};
    sum  = {1'b0, sq_x} + {1'b0, sq_y};
    return sum <= 9'(R_SQ);
  endfunction

  // A point inside both circles is still one covered point.
  logic covered;
  assign covered = in_circle(mem_x[idx], mem_y[idx], res_c1x_q, res_c1y_q) |
                   in_circle(mem_x[idx], mem_y[idx], res_c2x_q, res_c2y_q);

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking assignments would make the order of the
  // statements change the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      wait_cnt      <= '0;
      x_q           <= '0;
      y_q           <= '0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_c1x_q     <= '0;
      res_c1y_q     <= '0;
      res_c2x_q     <= '0;
      res_c2y_q     <= '0;
      res_cover_q   <= '0;
    end else begin
      res_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            // present point 0 in the very first SEND cycle
            state <= S_SEND;
            idx   <= '0;
            x_q   <= mem_x[0];
            y_q   <= mem_y[0];
          end
        end

        S_SEND: begin
          if (idx == 6'(N_PTS - 1)) begin
            state    <= S_WAIT;
            x_q      <= '0;
            y_q      <= '0;
            wait_cnt <= '0;
          end else begin
            idx <= idx + 6'd1;
            x_q <= mem_x[idx + 6'd1];
            y_q <= mem_y[idx + 6'd1];
          end
        end

        S_WAIT: begin
          // done wins over the timeout when both land in the same cycle
          if (bus.done) begin
            res_c1x_q     <= bus.c1x;
            res_c1y_q     <= bus.c1y;
            res_c2x_q     <= bus.c2x;
            res_c2y_q     <= bus.c2y;
            res_timeout_q <= 1'b0;
            res_cover_q   <= '0;
            idx           <= '0;
            state         <= S_SCORE;
          end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
            res_c1x_q     <= '0;
            res_c1y_q     <= '0;
            res_c2x_q     <= '0;
            res_c2y_q     <= '0;
            res_timeout_q <= 1'b1;
            res_cover_q   <= '0;
            res_valid_q   <= 1'b1;
            state         <= S_REPORT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        S_SCORE: begin
          res_cover_q <= res_cover_q + 6'(covered);
          if (idx == 6'(N_PTS - 1)) begin
            res_valid_q <= 1'b1;
            state       <= S_REPORT;
          end else begin
            idx <= idx + 6'd1;
          end
        end

        S_REPORT: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.res_c1x     = res_c1x_q;
  assign bus.res_c1y     = res_c1y_q;
  assign bus.res_c2x     = res_c2x_q;
  assign bus.res_c2y     = res_c2y_q;
  assign bus.res_cover   = res_cover_q;

endmodule

// File: tb/tb_laser_host.sv
// ---------------------------------------------------------------------------
// tb_laser_host
// Directed bench for laser_host. Loads point sets, plays the engine (done
// pulse with centres after a chosen number of WAIT cycles, or never), and
// checks the streamed X/Y sequence, latency, result bus, timeout, reset
// behaviour and memory retention against hand-computed values.
// ---------------------------------------------------------------------------
module tb_laser_host;

  localparam int N_PTS   = 40;
  localparam int TIMEOUT = 8192;

  logic clk;
  logic rst_n;

  laser_host_if bus ();

  laser_host #(.N_PTS(N_PTS), .R_SQ(16), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // copy of what the bench believes is in the point memory
  logic [3:0] mem_x [N_PTS];
  logic [3:0] mem_y [N_PTS];
  int         last_cover = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_pt(input int i, input logic [3:0] px, input logic [3:0] py);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 6'(i);
    bus.wr_x    = px;
    bus.wr_y    = py;
    mem_x[i]    = px;
    mem_y[i]    = py;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic set_centres(input logic [3:0] ax, input logic [3:0] ay,
                             input logic [3:0] bx, input logic [3:0] by);
    bus.c1x = ax;
    bus.c1y = ay;
    bus.c2x = bx;
    bus.c2y = by;
  endtask

  // One run, entered at a negedge in IDLE. w = WAIT cycles before done (w>=1);
  // disturb pulses done and a write during SEND, both of which must be ignored.
  task automatic run(input string tag, input int w, input bit give_done,
                     input logic [3:0] ax, input logic [3:0] ay,
                     input logic [3:0] bx, input logic [3:0] by,
                     input int exp_cover, input bit keep_start, input bit disturb);
    int lat;
    int xy_err;
    int budget;
    bit seen;
    lat    = 0;
    xy_err = 0;
    seen   = 1'b0;
    budget = give_done ? w + N_PTS + 5 : TIMEOUT + 5;

    bus.start = 1'b1;
    @(negedge clk);
    lat++;
    if (!keep_start) bus.start = 1'b0;
    check({tag, ".busy"}, 32'(bus.busy), 1);
    check({tag, ".cover_held"}, 32'(bus.res_cover), 32'(last_cover));

    for (int i = 0; i < N_PTS; i++) begin
      if (i > 0) begin
        @(negedge clk);
        lat++;
      end
      if (bus.x !== mem_x[i] || bus.y !== mem_y[i]) xy_err++;
      if (disturb && i == 10) begin
        bus.done = 1'b1;
        set_centres(4'd9, 4'd9, 4'd9, 4'd9);
      end else begin
        bus.done = 1'b0;
        set_centres(4'd0, 4'd0, 4'd0, 4'd0);
      end
      if (disturb && i == 20) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 6'd5;
        bus.wr_x    = 4'd15;
        bus.wr_y    = 4'd15;
      end else begin
        bus.wr_en = 1'b0;
      end
    end
    check({tag, ".xy_errors"}, 32'(xy_err), 0);

    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      lat++;
      if (k == 1) check({tag, ".xy_idle"}, 32'({bus.x, bus.y}), 0);
      if (bus.res_valid) begin
        seen = 1'b1;
        break;
      end
      if (give_done && k == w) begin
        bus.done = 1'b1;
        set_centres(ax, ay, bx, by);
      end else begin
        bus.done = 1'b0;
        set_centres(4'd0, 4'd0, 4'd0, 4'd0);
      end
    end
    bus.done = 1'b0;
    set_centres(4'd0, 4'd0, 4'd0, 4'd0);

    check({tag, ".res_valid_seen"}, 32'(seen), 1);
    // negedges after the start cycle: SEND + WAIT (+ SCORE) + REPORT
    if (seen)
      check({tag, ".latency"}, 32'(lat),
            give_done ? 32'(2 * N_PTS + w + 1) : 32'(N_PTS + TIMEOUT + 1));
    check({tag, ".cover"},   32'(bus.res_cover),   32'(exp_cover));
    check({tag, ".timeout"}, 32'(bus.res_timeout), give_done ? 0 : 1);
    check({tag, ".c1x"}, 32'(bus.res_c1x), give_done ? 32'(ax) : 0);
    check({tag, ".c1y"}, 32'(bus.res_c1y), give_done ? 32'(ay) : 0);
    check({tag, ".c2x"}, 32'(bus.res_c2x), give_done ? 32'(bx) : 0);
    check({tag, ".c2y"}, 32'(bus.res_c2y), give_done ? 32'(by) : 0);

    @(negedge clk);
    check({tag, ".valid_one_cycle"}, 32'(bus.res_valid), 0);
    check({tag, ".idle_after"}, 32'(bus.busy), 0);
    check({tag, ".cover_hold"}, 32'(bus.res_cover), 32'(exp_cover));
    last_cover = exp_cover;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_x    = '0;
    bus.wr_y    = '0;
    bus.start   = 1'b0;
    bus.done    = 1'b0;
    set_centres(4'd0, 4'd0, 4'd0, 4'd0);

    // reset state
    repeat (3) @(negedge clk);
    check("rst.busy",      32'(bus.busy), 0);
    check("rst.xy",        32'({bus.x, bus.y}), 0);
    check("rst.res_valid", 32'(bus.res_valid), 0);
    check("rst.cover",     32'(bus.res_cover), 0);
    check("rst.timeout",   32'(bus.res_timeout), 0);
    check("rst.centres",   32'({bus.res_c1x, bus.res_c1y, bus.res_c2x, bus.res_c2y}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: every point on circle-1 centre
    for (int i = 0; i < N_PTS; i++) load_pt(i, 4'd3, 4'd3);
    run("t1", 5, 1'b1, 4'd3, 4'd3, 4'd12, 4'd12, 40, 1'b0, 1'b0);

    // 2: two clusters, each 8 from its centre; then both circles at (2,2),
    // run back to back with start held high
    for (int i = 0; i < N_PTS; i++)
      if (i < 20) load_pt(i, 4'd0, 4'd0);
      else        load_pt(i, 4'd15, 4'd15);
    run("t2a", 3, 1'b1, 4'd2, 4'd2, 4'd13, 4'd13, 40, 1'b1, 1'b0);
    run("t2b", 1, 1'b1, 4'd2, 4'd2, 4'd2, 4'd2, 20, 1'b0, 1'b0);

    // 3: (7,3) is exactly 16 from (3,3): in; (7,4) is 17 from (3,3) and
    // 25 from (3,7): out; (3,3) is inside both circles and counts once
    load_pt(0, 4'd7, 4'd3);
    load_pt(1, 4'd7, 4'd4);
    load_pt(2, 4'd3, 4'd3);
    for (int i = 3; i < N_PTS; i++) load_pt(i, 4'd15, 4'd15);
    run("t3", 4, 1'b1, 4'd3, 4'd3, 4'd3, 4'd7, 2, 1'b0, 1'b0);

    // 4: engine never answers; then a late done in IDLE must do nothing
    run("t4", 1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b0, 1'b0);
    bus.done = 1'b1;
    set_centres(4'd5, 4'd5, 4'd5, 4'd5);
    @(negedge clk);
    bus.done = 1'b0;
    set_centres(4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    check("t4.late_done_busy",    32'(bus.busy), 0);
    check("t4.late_done_c1x",     32'(bus.res_c1x), 0);
    check("t4.late_done_timeout", 32'(bus.res_timeout), 1);

    // 5: grid x=i%16, y=i/16; circles at (0,0) (13 points) and (15,0)
    // (9 points) -> 22. done and a write to point 5 during SEND are ignored.
    for (int i = 0; i < N_PTS; i++) load_pt(i, 4'(i % 16), 4'(i / 16));
    run("t5", 3, 1'b1, 4'd0, 4'd0, 4'd15, 4'd0, 22, 1'b0, 1'b1);

    // 6: reset in the middle of SCORE, then rerun on the retained memory
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (N_PTS - 1) @(negedge clk);
    repeat (2) @(negedge clk);
    bus.done = 1'b1;
    set_centres(4'd0, 4'd0, 4'd15, 4'd0);
    @(negedge clk);
    bus.done = 1'b0;
    set_centres(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (10) @(negedge clk);
    check("t6.mid_busy", 32'(bus.busy), 1);
    check("t6.mid_c2x",  32'(bus.res_c2x), 15);
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst_busy",    32'(bus.busy), 0);
    check("t6.rst_valid",   32'(bus.res_valid), 0);
    check("t6.rst_cover",   32'(bus.res_cover), 0);
    check("t6.rst_timeout", 32'(bus.res_timeout), 0);
    check("t6.rst_centres", 32'({bus.res_c1x, bus.res_c1y, bus.res_c2x, bus.res_c2y}), 0);
    repeat (2) @(negedge clk);
    check("t6.rst_no_valid", 32'(bus.res_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    last_cover = 0;
    run("t6", 2, 1'b1, 4'd0, 4'd0, 4'd15, 4'd0, 22, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
